pad_strip: RTL and testbench
============================

# pad_strip

Receive-side counterpart of the boundary-padding stage. Consumes a zero-padded RGB pixel stream, the same framing the filter input sees, and discards every padding pixel. Emits only the width×height active pixels with their coordinates and a frame-done pulse. Sits after the kernel filter, or on a verification tap, so downstream stages such as rgb2ycc see an unpadded frame.

## Interface
- width, 320, active pixels per row
- height, 240, active rows per frame
- kernelSize, 3, filter kernel size (odd); B = (kernelSize-1)/2 is the padding depth
- dataWidth, 24, pixel width ({R,G,B})
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- newFrame  in  1  one-cycle pulse marking the start of a padded frame
- iValid  in  1  iData is a valid padded-stream pixel this cycle
- iData  in  dataWidth  padded pixel
- oData  out  dataWidth  active pixel
- oValid  out  1  oData is valid this cycle
- xCnt  out  16  column of oData, 0..width-1
- yCnt  out  16  row of oData, 0..height-1
- oDone  out  1  one-cycle pulse, coincident with the last active pixel
- oPadErrCnt  out  16  nonzero padding pixels seen in the current frame; saturates at 0xFFFF
- oFrameErr  out  1  sticky; set when a frame is aborted

## Operation
- Padded frame layout is decided as follows:
  - (height+2B) rows of (width+2B) pixels each, row-major.
  - Active pixel (x,y) sits at padded column x+B, padded row y+B.
  - All other pixels are padding and nominally zero.
- Internal counters:
  - pc: padded column, 0..width+2B-1.
  - pr: padded row, 0..height+2B-1.
  - Both advance only on accepted pixels (iValid in RUN).
  - pc wraps to 0 after width+2B-1 and increments pr.
- FSM states are IDLE, RUN and DONE.
  - IDLE: iValid is ignored. newFrame moves to RUN, clears pc, pr and oPadErrCnt.
  - RUN: each accepted pixel is classified.
    - Active when B ≤ pc < B+width and B ≤ pr < B+height. The pixel is forwarded.
    - Padding otherwise. The pixel is dropped. If iData ≠ 0, oPadErrCnt increments (saturating).
    - On acceptance of the final padded pixel (pc=width+2B-1, pr=height+2B-1), move to DONE.
  - DONE: lasts one cycle, then IDLE. iValid in DONE is ignored. newFrame in DONE is honoured as in IDLE, going straight to RUN.
- newFrame in RUN aborts the current frame:
  - oFrameErr is set.
  - Counters restart and the state stays RUN.
  - oDone is not pulsed for the aborted frame.
- newFrame and iValid in the same cycle: that pixel is padded pixel (0,0) of the new frame. This applies from IDLE, RUN or DONE.
- kernelSize=1 (B=0): every pixel is active and the block is a pass-through with coordinates.

## Timing
- Reset values:
  - oData=0, oValid=0, xCnt=0, yCnt=0, oDone=0, oPadErrCnt=0, oFrameErr=0.
  - FSM in IDLE, pc=pr=0.
- Latency is 1 cycle: the active pixel accepted at cycle n appears at cycle n+1 with oValid=1 and its xCnt/yCnt.
  - oData, xCnt and yCnt hold their last values when oValid=0.
- xCnt = pc-B and yCnt = pr-B are registered alongside oData.
- oDone is asserted in the same cycle as oValid for pixel (width-1, height-1).
  - Trailing padding still must be consumed before the FSM leaves RUN.
- There is no backpressure; the block accepts a pixel every cycle iValid is high. Gaps of any length between pixels are allowed.
- oPadErrCnt updates one cycle after the offending pixel. It is valid for the frame until the next newFrame.
- oFrameErr clears only on reset.
- Reset asserted mid-frame takes effect immediately: all outputs return to their reset values and the FSM goes to IDLE.

## Test plan
Parameters for all scenarios: width=4, height=3, kernelSize=3 (B=1, padded frame 6×5 = 30 pixels).
- Clean frame:
  - Stimulus: newFrame, then 30 back-to-back pixels with zero padding and active pixels = 0x000100+index.
  - Required: exactly 12 oValid pulses, in raster order, with xCnt/yCnt 0..3 / 0..2.
  - Required: oDone is high only with (3,2), 1 cycle after the 23rd accepted pixel (padded (4,3)), and oPadErrCnt=0.
- Gapped input:
  - Stimulus: same frame with iValid toggling 1,0,0,1...
  - Required: identical output sequence and coordinates; each output appears 1 cycle after its input.
- Padding error:
  - Stimulus: frame with padded pixels (0,0) and (5,4) = 0xFFFFFF.
  - Required: oPadErrCnt=2 after the frame ends; active output is unchanged.
- Abort:
  - Stimulus: newFrame at padded pixel 15, then a full clean frame.
  - Required: oFrameErr=1, no oDone for the first frame, and the second frame outputs 12 correct pixels with oDone.
- Simultaneous start:
  - Stimulus: newFrame and iValid in the same cycle with iData=0x0.
  - Required: that pixel counts as padded (0,0); the first oValid carries padded pixel 7 (active (0,0)).
- Reset mid-frame:
  - Stimulus: assert reset low at padded pixel 10.
  - Required: all outputs are 0 asynchronously, the rest of the stream is ignored until newFrame, and the next frame is processed cleanly.

Source files
------------

// File: rtl/pad_strip.sv
// pad_strip: drops the zero-padding border of a padded RGB frame and forwards active pixels with coordinates.
module pad_strip #(
  parameter int width = 320,
  parameter int height = 240,
  parameter int kernelSize = 3,
  parameter int dataWidth = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 newFrame,
  input  logic                 iValid,
  input  logic [dataWidth-1:0] iData,
  output logic [dataWidth-1:0] oData,
  output logic                 oValid,
  output logic [15:0]          xCnt,
  output logic [15:0]          yCnt,
  output logic                 oDone,
  output logic [15:0]          oPadErrCnt,
  output logic                 oFrameErr
);
  localparam int B = (kernelSize - 1) / 2;
  localparam logic [15:0] padB = 16'(B);
  localparam logic [15:0] lastCol = 16'(width + 2 * B - 1);
  localparam logic [15:0] lastRow = 16'(height + 2 * B - 1);
  localparam logic [15:0] endCol = 16'(B + width);
  localparam logic [15:0] endRow = 16'(B + height);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [15:0] pc, pr, curPc, curPr, nextPc, nextPr, errBase;
  logic acc, active, last;
  // newFrame makes the pixel of the same cycle padded (0,0) of the new frame
  always_comb begin
    curPc = newFrame ? '0 : pc;
    curPr = newFrame ? '0 : pr;
    acc = iValid && (newFrame || state == RUN);
    active = curPc >= padB && curPc < endCol && curPr >= padB && curPr < endRow;
    last = curPc == lastCol && curPr == lastRow;
    nextPc = (curPc == lastCol || last) ? '0 : curPc + 16'd1;
    nextPr = last ? '0 : (curPc == lastCol ? curPr + 16'd1 : curPr);
    errBase = newFrame ? '0 : oPadErrCnt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc <= '0;
      pr <= '0;
      oData <= '0;
      oValid <= 1'b0;
      xCnt <= '0;
      yCnt <= '0;
      oDone <= 1'b0;
      oPadErrCnt <= '0;
      oFrameErr <= 1'b0;
    end else begin
      oValid <= acc && active;
      oDone <= acc && active && curPc == endCol - 16'd1 && curPr == endRow - 16'd1;
      if (acc && active) begin
        oData <= iData;
        xCnt <= curPc - padB;
        yCnt <= curPr - padB;
      end
      if (newFrame && state == RUN) oFrameErr <= 1'b1;
      if (acc || newFrame) begin
        pc <= acc ? nextPc : '0;
        pr <= acc ? nextPr : '0;
      end
      oPadErrCnt <= (acc && !active && iData != '0 && errBase != 16'hFFFF) ? errBase + 16'd1 : errBase;
      state <= (acc && last) ? DONE : (newFrame ? RUN : (state == DONE ? IDLE : state));
    end
  end
endmodule

// File: tb/tb_pad_strip.sv
// tb_pad_strip: randomized scoreboard bench for pad_strip on a 4x3 frame with a 3x3 kernel.
module tb_pad_strip;
  localparam int W = 4, H = 3, K = 3, B = 1, PW = W + 2 * B, PH = H + 2 * B, N = PW * PH;
  logic clk = 0, reset = 0, newFrame = 0, iValid = 0;
  logic [23:0] iData = '0, oData;
  logic oValid, oDone, oFrameErr;
  logic [15:0] xCnt, yCnt, oPadErrCnt;
  int total = 0, bad = 0, cyc = 0, doneCnt = 0;
  typedef struct {logic [23:0] d; int x; int y; bit done; int stamp;} exp_t;
  exp_t sb[$];

  pad_strip #(.width(W), .height(H), .kernelSize(K), .dataWidth(24)) dut (
    .clk(clk), .reset(reset), .newFrame(newFrame), .iValid(iValid), .iData(iData),
    .oData(oData), .oValid(oValid), .xCnt(xCnt), .yCnt(yCnt), .oDone(oDone),
    .oPadErrCnt(oPadErrCnt), .oFrameErr(oFrameErr));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every presented output must match the oldest expected pixel, at its expected cycle
  always @(negedge clk) begin
    if (reset && oValid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got d=%h x=%0d y=%0d want no output", oData, xCnt, yCnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (oData !== e.d || xCnt !== 16'(e.x) || yCnt !== 16'(e.y) || oDone !== e.done || cyc != e.stamp) begin
          bad++;
          $display("FAIL pixel got d=%h x=%0d y=%0d done=%0b cyc=%0d want d=%h x=%0d y=%0d done=%0b cyc=%0d",
                   oData, xCnt, yCnt, oDone, cyc, e.d, e.x, e.y, e.done, e.stamp);
        end
      end
      if (oDone) doneCnt++;
    end else if (reset && oDone) begin
      total++;
      bad++;
      $display("FAIL done_without_valid got oDone=1 want 0");
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive(input bit nf, input bit v, input logic [23:0] d);
    @(posedge clk);
    #1;
    newFrame = nf;
    iValid = v;
    iData = d;
  endtask

  task automatic idle(input int n, input bit junk);
    repeat (n) drive(0, junk ? 1'($urandom_range(0, 1)) : 1'b0, 24'($urandom));
  endtask

  // sends the first npix padded pixels; gap: 0 none, 1 two idle cycles, 2 random
  // err: 0 clean, 1 corners (0,0)/(5,4) = FFFFFF, 2 random nonzero padding
  task automatic send_frame(input int npix, input bit simul, input int gap, input int err, input bit rnd, output int nerr);
    nerr = 0;
    if (!simul) drive(1, 0, 24'($urandom));
    for (int i = 0; i < npix; i++) begin
      int c, r, n;
      bit act;
      logic [23:0] d;
      exp_t e;
      c = i % PW;
      r = i / PW;
      act = c >= B && c < B + W && r >= B && r < B + H;
      if (act) d = rnd ? 24'($urandom) : 24'h000100 + 24'(i);
      else if (err == 1 && (i == 0 || i == N - 1)) d = 24'hFFFFFF;
      else if (err == 2 && $urandom_range(0, 3) == 0) d = 24'($urandom_range(1, 24'hFFFFFF));
      else d = '0;
      if (!act && d != 0) nerr++;
      drive(simul && i == 0, 1, d);
      if (act) begin
        e.d = d; e.x = c - B; e.y = r - B; e.done = (c - B == W - 1) && (r - B == H - 1); e.stamp = cyc + 1;
        sb.push_back(e);
      end
      n = gap == 1 ? 2 : gap == 2 ? int'($urandom_range(0, 3)) : 0;
      repeat (n) drive(0, 0, 24'($urandom));
    end
  endtask

  task automatic end_frame(input string name, input int d0, input int wantDone, input int wantErr, input bit wantFerr);
    idle(3, 0);
    chk({name, "_padErr"}, 32'(oPadErrCnt), 32'(wantErr));
    chk({name, "_doneCnt"}, 32'(doneCnt - d0), 32'(wantDone));
    chk({name, "_frameErr"}, 32'(oFrameErr), 32'(wantFerr));
    chk({name, "_drained"}, 32'(sb.size()), 0);
  endtask

  initial begin
    int ne, d0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {oData, oValid, oDone, oFrameErr}, 0);
    chk("reset_cnts", {xCnt, yCnt}, 0);
    chk("reset_padErr", 32'(oPadErrCnt), 0);
    reset = 1;
    idle(4, 1);
    d0 = doneCnt; send_frame(N, 0, 0, 0, 0, ne); end_frame("clean", d0, 1, 0, 0);
    d0 = doneCnt; send_frame(N, 0, 1, 0, 0, ne); end_frame("gapped", d0, 1, 0, 0);
    d0 = doneCnt; send_frame(N, 0, 0, 1, 0, ne); end_frame("padErr", d0, 1, 2, 0);
    d0 = doneCnt; send_frame(15, 0, 0, 0, 0, ne); send_frame(N, 0, 0, 0, 0, ne); end_frame("abort", d0, 1, 0, 1);
    d0 = doneCnt; send_frame(N, 1, 0, 0, 0, ne); end_frame("simul", d0, 1, 0, 1);
    send_frame(10, 0, 0, 0, 0, ne);
    drive(0, 1, 24'h123456);
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    chk("midreset_outs", {oData, oValid, oDone, oFrameErr}, 0);
    chk("midreset_cnts", {xCnt, yCnt, oPadErrCnt}, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    idle(6, 1);
    d0 = doneCnt; send_frame(N, 0, 0, 0, 0, ne); end_frame("postreset", d0, 1, 0, 0);
    for (int f = 0; f < 8; f++) begin
      d0 = doneCnt;
      send_frame(N, 1'($urandom_range(0, 1)), 2, 2, 1, ne);
      if (f % 2 == 0) begin
        int d1, ne2;
        d1 = doneCnt;
        send_frame(N, 1, 2, 2, 1, ne2);
        end_frame("rand_b2b", d0, 2, ne2, 0);
      end else end_frame("rand", d0, 1, ne, 0);
      idle(int'($urandom_range(0, 4)), 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
